mode_switch_controller: RTL and testbench
=========================================

Name: mode_switch_controller

Overview:
- Parametrised successor to the RF transceiver mode controller.
- Synchronises and debounces an N-bit external mode request, commits it only while the transceiver core reports idle, then drives AUX low for a mode-dependent settle time.
- Adds a longer wake-up settle when leaving the sleep mode, a pending indicator, a previous-mode record and a completion pulse.
- Sits between the host mode pins (M0/M1/...) and the transceiver state controller.

Parameters:
MODE_W, 2, width of mode request/outputs (>=1)
DEFAULT_MODE, 3, mode loaded into mode_sync/prev_mode on reset
SYNC_STAGES, 2, flop stages on mode_req before use (>=2)
STABLE_CYCLES, 16, consecutive edges a new synchronised request must hold before commit (>=1)
SWITCH_CYCLES, 10000, AUX low time for a normal switch (>=1)
SLEEP_MODE, 3, mode code treated as sleep
WAKE_EXTRA_CYCLES, 5000, extra AUX low time when leaving SLEEP_MODE (>=0)

Ports:
internal_clk  in   1       clock
rst_n         in   1       synchronous, active-low reset
mode_req      in   MODE_W  asynchronous host mode request
AUX_state_ctrl in  1       1 = transceiver core idle, switch allowed
AUX_mode_ctrl out  1       0 = mode switch in progress
mode_sync     out  MODE_W  committed mode
prev_mode     out  MODE_W  mode before last commit
req_pending   out  1       1 while a differing request is qualifying
mode_done     out  1       one-cycle pulse at switch completion

Behaviour:
- Reset is synchronous to internal_clk, active-low on rst_n; clock is internal_clk.
- Reset values: AUX_mode_ctrl=1, mode_sync=prev_mode=DEFAULT_MODE, req_pending=0, mode_done=0, all sync stages=DEFAULT_MODE, state=IDLE, counters=0.
- req_s is the last sync stage; a change on mode_req is visible on req_s SYNC_STAGES edges later.
- Reset mid-operation aborts any qualify or switch, with no mode_done pulse.
- IDLE:
  - If req_s==mode_sync, stay.
  - Else latch cand=req_s and set stab=1.
  - If STABLE_CYCLES==1 and AUX_state_ctrl=1, commit on this edge.
  - Otherwise go to QUALIFY with req_pending=1.
- QUALIFY, evaluated each edge:
  - req_s==mode_sync: return to IDLE, req_pending=0, no commit.
  - req_s!=cand (and !=mode_sync): cand=req_s, stab=1.
  - req_s==cand: stab saturates at STABLE_CYCLES.
  - Commit when req_s==cand, stab (after update) >= STABLE_CYCLES and AUX_state_ctrl=1.
  - If AUX_state_ctrl=0, hold in QUALIFY indefinitely; commit on the first edge it reads 1 with the request still stable.
- Commit edge:
  - prev_mode<=mode_sync, mode_sync<=cand, AUX_mode_ctrl<=0, req_pending<=0.
  - Load duration N = SWITCH_CYCLES + (mode_sync==SLEEP_MODE && cand!=SLEEP_MODE ? WAKE_EXTRA_CYCLES : 0).
  - Enter SWITCH.
- SWITCH:
  - AUX_mode_ctrl stays 0 for exactly N cycles, then returns to 1.
  - mode_done=1 for the single cycle in which AUX_mode_ctrl first reads 1 again; go to IDLE.
  - mode_req changes are ignored during SWITCH; they are re-evaluated from IDLE (full qualification) after completion.
  - AUX_state_ctrl is ignored during SWITCH.
- Counter width: $clog2(SWITCH_CYCLES+WAKE_EXTRA_CYCLES+1). The stability counter saturates and never wraps.
- Entering SLEEP_MODE from any mode uses SWITCH_CYCLES only.
- Never more than one commit per SWITCH; back-to-back switches are separated by at least one IDLE edge plus qualification.

Test Plan:
(bench params: SYNC_STAGES=2, STABLE_CYCLES=4, SWITCH_CYCLES=20, WAKE_EXTRA_CYCLES=10, DEFAULT_MODE=3)
- Reset check: rst_n=0 for 3 edges -> mode_sync=3, prev_mode=3, AUX_mode_ctrl=1, req_pending=0, mode_done=0.
- Wake switch: mode_req 3->0 held, AUX_state_ctrl=1 -> mode_sync=0 and AUX low 2+4 edges after change; AUX low 30 cycles; prev_mode=3; one mode_done pulse.
- Normal switch: from 0, mode_req=1 -> AUX low exactly 20 cycles; mode_sync=1, prev_mode=0.
- Glitch rejection: mode_req=2 for 2 cycles then back to 1 -> req_pending pulses; mode_sync stays 1; AUX stays 1; no mode_done.
- Busy hold: AUX_state_ctrl=0, mode_req=2 held 50 cycles -> mode_sync stays 1, req_pending=1; raise AUX_state_ctrl -> commit on that edge.
- Mid-switch events:
  - mode_req changes 2->0 during a SWITCH -> first switch completes unchanged, then 0 qualifies and a second 20-cycle switch follows.
  - rst_n=0 mid-switch -> mode_sync=3, AUX_mode_ctrl=1, no mode_done.

Source files
------------

// File: rtl/mode_switch_controller.sv
// Mode switch controller: synchronises and debounces a host mode request, commits it while the
// transceiver core is idle, then holds AUX low for a mode-dependent settle time.
module mode_switch_controller #(
  parameter int unsigned MODE_W            = 2,
  parameter int unsigned DEFAULT_MODE      = 3,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned STABLE_CYCLES     = 16,
  parameter int unsigned SWITCH_CYCLES     = 10000,
  parameter int unsigned SLEEP_MODE        = 3,
  parameter int unsigned WAKE_EXTRA_CYCLES = 5000
) (
  input  logic              internal_clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              AUX_state_ctrl,
  output logic              AUX_mode_ctrl,
  output logic [MODE_W-1:0] mode_sync,
  output logic [MODE_W-1:0] prev_mode,
  output logic              req_pending,
  output logic              mode_done
);

  localparam int unsigned CntW  = $clog2(SWITCH_CYCLES + WAKE_EXTRA_CYCLES + 1);
  localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);

  localparam logic [MODE_W-1:0] DefMode   = MODE_W'(DEFAULT_MODE);
  localparam logic [MODE_W-1:0] SleepMode = MODE_W'(SLEEP_MODE);
  localparam logic [CntW-1:0]   SwitchLen = CntW'(SWITCH_CYCLES);
  localparam logic [CntW-1:0]   WakeLen   = CntW'(SWITCH_CYCLES + WAKE_EXTRA_CYCLES);
  localparam logic [StabW-1:0]  StableMax = StabW'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StQualify, StSwitch} state_e;

  state_e            state_q;
  logic [MODE_W-1:0] sync_q [SYNC_STAGES];
  logic [MODE_W-1:0] req_s;
  logic [MODE_W-1:0] cand_q;
  logic [StabW-1:0]  stab_q;
  logic [StabW-1:0]  stab_inc;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   switch_len;
  logic              commit;

  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= DefMode;
    end else begin
      sync_q[0] <= mode_req;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    stab_inc = stab_q;
    if (stab_q < StableMax) stab_inc = stab_q + StabW'(1);
    // Only leaving sleep for a different mode earns the wake-up extension.
    switch_len = (mode_sync == SleepMode) ? WakeLen : SwitchLen;
    commit = 1'b0;
    case (state_q)
      StIdle:    commit = (req_s != mode_sync) && (STABLE_CYCLES == 1) && AUX_state_ctrl;
      StQualify: commit = (req_s != mode_sync) && AUX_state_ctrl &&
                          ((req_s == cand_q) ? (stab_inc >= StableMax) : (STABLE_CYCLES == 1));
      default:   commit = 1'b0;
    endcase
  end

  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cand_q        <= DefMode;
      stab_q        <= '0;
      cnt_q         <= '0;
      AUX_mode_ctrl <= 1'b1;
      mode_sync     <= DefMode;
      prev_mode     <= DefMode;
      req_pending   <= 1'b0;
      mode_done     <= 1'b0;
    end else begin
      mode_done <= 1'b0;
      if (commit) begin
        prev_mode     <= mode_sync;
        mode_sync     <= req_s;
        cand_q        <= req_s;
        stab_q        <= '0;
        AUX_mode_ctrl <= 1'b0;
        req_pending   <= 1'b0;
        cnt_q         <= switch_len;
        state_q       <= StSwitch;
      end else begin
        case (state_q)
          StIdle: begin
            if (req_s != mode_sync) begin
              cand_q      <= req_s;
              stab_q      <= StabW'(1);
              req_pending <= 1'b1;
              state_q     <= StQualify;
            end
          end
          StQualify: begin
            if (req_s == mode_sync) begin
              req_pending <= 1'b0;
              state_q     <= StIdle;
            end else if (req_s != cand_q) begin
              cand_q <= req_s;
              stab_q <= StabW'(1);
            end else begin
              stab_q <= stab_inc;
            end
          end
          StSwitch: begin
            // Request and core-idle inputs are deliberately ignored until the settle ends.
            if (cnt_q <= CntW'(1)) begin
              AUX_mode_ctrl <= 1'b1;
              mode_done     <= 1'b1;
              state_q       <= StIdle;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mode_switch_controller.sv
// Bench for mode_switch_controller: directed scenarios plus random stimulus, all outputs compared
// every cycle against a run-length based reference model.
module tb_mode_switch_controller;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned DEF     = 3;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned STABLE  = 4;
  localparam int unsigned SWITCH  = 20;
  localparam int unsigned SLEEP   = 3;
  localparam int unsigned WAKE    = 10;

  logic              clk;
  logic              rst_n;
  logic [MODE_W-1:0] mode_req;
  logic              aux_state;
  logic              aux_mode;
  logic [MODE_W-1:0] mode_sync;
  logic [MODE_W-1:0] prev_mode;
  logic              req_pending;
  logic              mode_done;

  int n_checks = 0;
  int n_pass   = 0;

  mode_switch_controller #(
    .MODE_W           (MODE_W),
    .DEFAULT_MODE     (DEF),
    .SYNC_STAGES      (SYNC),
    .STABLE_CYCLES    (STABLE),
    .SWITCH_CYCLES    (SWITCH),
    .SLEEP_MODE       (SLEEP),
    .WAKE_EXTRA_CYCLES(WAKE)
  ) dut (
    .internal_clk  (clk),
    .rst_n         (rst_n),
    .mode_req      (mode_req),
    .AUX_state_ctrl(aux_state),
    .AUX_mode_ctrl (aux_mode),
    .mode_sync     (mode_sync),
    .prev_mode     (prev_mode),
    .req_pending   (req_pending),
    .mode_done     (mode_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: request seen through a SYNC-deep delay line; a commit happens once the
  // delayed request has differed from the committed mode with the same value for STABLE
  // consecutive evaluated edges and the core reports idle.
  logic [MODE_W-1:0] m_q[$];
  logic [MODE_W-1:0] m_mode, m_prev, m_run_val, m_rs;
  logic              m_aux, m_pend, m_done;
  int                m_busy, m_run_len;
  bit                model_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < SYNC; i++) m_q.push_back(MODE_W'(DEF));
      m_mode = MODE_W'(DEF);
      m_prev = MODE_W'(DEF);
      m_aux = 1'b1; m_pend = 1'b0; m_done = 1'b0;
      m_busy = 0; m_run_len = 0; m_run_val = '0;
      model_valid = 1;
    end else if (model_valid) begin
      m_rs = m_q.pop_front();
      m_q.push_back(mode_req);
      m_done = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_aux = 1'b1; m_done = 1'b1; m_run_len = 0;
        end
      end else begin
        if (m_run_len > 0 && m_rs == m_run_val) m_run_len++;
        else begin
          m_run_val = m_rs; m_run_len = 1;
        end
        if (m_rs != m_mode && m_run_len >= STABLE && aux_state) begin
          m_busy = SWITCH + ((m_mode == MODE_W'(SLEEP)) ? WAKE : 0);
          m_prev = m_mode; m_mode = m_rs;
          m_aux = 1'b0; m_pend = 1'b0; m_run_len = 0;
        end else begin
          m_pend = (m_rs != m_mode);
        end
      end
    end
  end

  int low_cnt, done_cnt, pend_cnt;

  always @(negedge clk) begin
    if (model_valid) begin
      check_eq("aux_mode", aux_mode, m_aux);
      check_eq("mode_sync", mode_sync, m_mode);
      check_eq("prev_mode", prev_mode, m_prev);
      check_eq("req_pending", req_pending, m_pend);
      check_eq("mode_done", mode_done, m_done);
    end
    if (aux_mode === 1'b0) low_cnt++;
    if (mode_done === 1'b1) done_cnt++;
    if (req_pending === 1'b1) pend_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    low_cnt = 0; done_cnt = 0; pend_cnt = 0;
  endtask

  // Apply a request and measure edges until AUX drops, bounded.
  task automatic request_and_time(input logic [MODE_W-1:0] m, input string tag);
    int n;
    clear_counts();
    mode_req = m;
    n = 0;
    while (aux_mode !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, n, SYNC + STABLE);
  endtask

  initial begin
    rst_n = 1'b0; mode_req = MODE_W'(DEF); aux_state = 1'b1;
    clear_counts();
    step(3);
    check_eq("rst_mode_sync", mode_sync, 3);
    check_eq("rst_prev_mode", prev_mode, 3);
    check_eq("rst_aux", aux_mode, 1);
    check_eq("rst_pending", req_pending, 0);
    check_eq("rst_done", mode_done, 0);
    rst_n = 1'b1;
    step(3);

    // Wake from sleep: 30-cycle settle.
    request_and_time(2'd0, "wake_latency");
    check_eq("wake_mode", mode_sync, 0);
    step(40);
    check_eq("wake_low_len", low_cnt, SWITCH + WAKE);
    check_eq("wake_done_cnt", done_cnt, 1);
    check_eq("wake_prev", prev_mode, 3);

    // Normal switch 0 -> 1.
    request_and_time(2'd1, "norm_latency");
    step(30);
    check_eq("norm_low_len", low_cnt, SWITCH);
    check_eq("norm_mode", mode_sync, 1);
    check_eq("norm_prev", prev_mode, 0);

    // Two-cycle glitch must not commit.
    clear_counts();
    mode_req = 2'd2;
    step(2);
    mode_req = 2'd1;
    step(20);
    check_eq("glitch_pend_cnt", pend_cnt, 2);
    check_eq("glitch_mode", mode_sync, 1);
    check_eq("glitch_low", low_cnt, 0);
    check_eq("glitch_done", done_cnt, 0);

    // Core busy: hold in qualification, commit on the edge idle returns.
    aux_state = 1'b0;
    mode_req = 2'd2;
    step(50);
    check_eq("busy_mode", mode_sync, 1);
    check_eq("busy_pending", req_pending, 1);
    clear_counts();
    aux_state = 1'b1;
    step(1);
    check_eq("busy_commit_aux", aux_mode, 0);
    check_eq("busy_commit_mode", mode_sync, 2);

    // Request change mid-switch: first switch finishes, then a second full switch.
    step(5);
    mode_req = 2'd0;
    step(80);
    check_eq("mid_done_cnt", done_cnt, 2);
    check_eq("mid_low_len", low_cnt, 2 * SWITCH);
    check_eq("mid_mode", mode_sync, 0);
    check_eq("mid_prev", prev_mode, 2);

    // Reset in the middle of a switch.
    request_and_time(2'd1, "rst_sw_latency");
    step(5);
    clear_counts();
    rst_n = 1'b0;
    step(2);
    check_eq("midrst_mode", mode_sync, 3);
    check_eq("midrst_aux", aux_mode, 1);
    check_eq("midrst_done", done_cnt, 0);
    rst_n = 1'b1;
    step(40);

    // Random phase.
    for (int it = 0; it < 60; it++) begin
      mode_req  = MODE_W'($urandom_range(0, 3));
      aux_state = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        step($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      step($urandom_range(1, 30));
    end
    step(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
